// File: rtl/cmul_16_pkg.sv
// rtl/cmul_16_pkg.sv - shared parameters and saturation helper for the complex multiplier
// Ports: none (package).
package cmul_16_pkg;

  localparam int WIDTH   = 16;
  localparam int LATENCY = 3;
  localparam int SHIFT   = 15;

  // Clamp bounds for a (2*WIDTH+1)-bit signed value: +2^(WIDTH-1)-1 and -2^(WIDTH-1).
  localparam logic signed [2*WIDTH:0] SAT_HI = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH:0] SAT_LO = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [2*WIDTH:0] x);
    logic signed [WIDTH-1:0] r;
    if (x > SAT_HI)      r = SAT_HI[WIDTH-1:0];
    else if (x < SAT_LO) r = SAT_LO[WIDTH-1:0];
    else                 r = x[WIDTH-1:0];
    return r;
  endfunction

endpackage

// File: rtl/cmul_16_if.sv
// rtl/cmul_16_if.sv - stream bundle for the complex multiplier
// Ports (signals): in_tvalid/in_tready/in_tlast/adata/bdata on the input side,
//                  out_tvalid/out_tready/out_tlast/pdata on the output side.
// modport slave is the multiplier's view, modport master the source/sink's view.
interface cmul_16_if;
  import cmul_16_pkg::*;

  logic                 in_tvalid;
  logic                 in_tlast;
  logic                 in_tready;
  logic [2*WIDTH-1:0]   adata;
  logic [2*WIDTH-1:0]   bdata;
  logic                 out_tvalid;
  logic                 out_tlast;
  logic                 out_tready;
  logic [2*WIDTH-1:0]   pdata;

  modport master (
    output in_tvalid, in_tlast, adata, bdata, out_tready,
    input  in_tready, out_tvalid, out_tlast, pdata
  );

  modport slave (
    input  in_tvalid, in_tlast, adata, bdata, out_tready,
    output in_tready, out_tvalid, out_tlast, pdata
  );

endinterface

// File: rtl/cmul_pipe_stage.sv
// rtl/cmul_pipe_stage.sv - one pipeline register (valid + data) with common enable
// Ports: clk, reset (async active-low clear), en (advance), in_valid/in_data,
//        out_valid/out_data.
module cmul_pipe_stage #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  // Data is captured even for bubbles; only the valid bit qualifies it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= in_data;
    end
  end

endmodule

// File: rtl/cmul_16.sv
// rtl/cmul_16.sv - pipelined Q1.15 complex multiplier p = a*b, three stages
// Ports: clk, reset (async active-low), s (cmul_16_if.slave):
//   adata/bdata {I,Q} in, in_tvalid/in_tlast/in_tready input handshake,
//   pdata {I,Q} out, out_tvalid/out_tlast/out_tready output handshake.
module cmul_16
  import cmul_16_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  cmul_16_if.slave     s
);

  localparam int S0W = 4*WIDTH + 1;
  localparam int S1W = 8*WIDTH + 1;
  localparam int S2W = 2*WIDTH + 1;

  logic en;

  logic           s0_valid, s1_valid, s2_valid;
  logic [S0W-1:0] s0_data;
  logic [S1W-1:0] s1_data, s1_next;
  logic [S2W-1:0] s2_data, s2_next;

  // Whole pipe stalls as one unit; a bubble in the output slot still lets it move.
  assign en          = s.out_tready | ~s.out_tvalid;
  assign s.in_tready = en;

  cmul_pipe_stage #(.DW(S0W)) u_stage0 (
    .clk(clk), .reset(reset), .en(en),
    .in_valid(s.in_tvalid), .in_data({s.in_tlast, s.adata, s.bdata}),
    .out_valid(s0_valid), .out_data(s0_data)
  );

  logic signed [WIDTH-1:0] ai, aq, bi, bq;
  logic signed [2*WIDTH-1:0] m_ii, m_qq, m_iq, m_qi;

  assign ai = s0_data[4*WIDTH-1:3*WIDTH];
  assign aq = s0_data[3*WIDTH-1:2*WIDTH];
  assign bi = s0_data[2*WIDTH-1:WIDTH];
  assign bq = s0_data[WIDTH-1:0];

  assign m_ii = ai * bi;
  assign m_qq = aq * bq;
  assign m_iq = ai * bq;
  assign m_qi = aq * bi;

  assign s1_next = {s0_data[S0W-1], m_ii, m_qq, m_iq, m_qi};

  cmul_pipe_stage #(.DW(S1W)) u_stage1 (
    .clk(clk), .reset(reset), .en(en),
    .in_valid(s0_valid), .in_data(s1_next),
    .out_valid(s1_valid), .out_data(s1_data)
  );

  logic signed [2*WIDTH-1:0] r_ii, r_qq, r_iq, r_qi;
  logic signed [2*WIDTH:0]   pi_full, pq_full, pi_sh, pq_sh;
  logic signed [WIDTH-1:0]   pi_sat, pq_sat;

  assign r_ii = s1_data[8*WIDTH-1:6*WIDTH];
  assign r_qq = s1_data[6*WIDTH-1:4*WIDTH];
  assign r_iq = s1_data[4*WIDTH-1:2*WIDTH];
  assign r_qi = s1_data[2*WIDTH-1:0];

  // One guard bit covers the only overflow case, (-1)*(-1) + (-1)*(-1) = 2.0.
  assign pi_full = {r_ii[2*WIDTH-1], r_ii} - {r_qq[2*WIDTH-1], r_qq};
  assign pq_full = {r_iq[2*WIDTH-1], r_iq} + {r_qi[2*WIDTH-1], r_qi};
  assign pi_sh   = pi_full >>> SHIFT;
  assign pq_sh   = pq_full >>> SHIFT;
  assign pi_sat  = saturate(pi_sh);
  assign pq_sat  = saturate(pq_sh);

  assign s2_next = {s1_data[S1W-1], pi_sat, pq_sat};

  cmul_pipe_stage #(.DW(S2W)) u_stage2 (
    .clk(clk), .reset(reset), .en(en),
    .in_valid(s1_valid), .in_data(s2_next),
    .out_valid(s2_valid), .out_data(s2_data)
  );

  assign s.out_tvalid = s2_valid;
  assign s.out_tlast  = s2_data[S2W-1];
  assign s.pdata      = s2_data[2*WIDTH-1:0];

endmodule

// File: tb/tb_cmul_16.sv
// tb/tb_cmul_16.sv - self-checking bench for cmul_16 against a queue-based arithmetic model
module tb_cmul_16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cmul_16_if bus();

  cmul_16 dut (.clk(clk), .reset(reset), .s(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, floor shift, clamp.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    longint ai, aq, bi, bq, pi, pq;
    logic [63:0] ui, uq;
    ai = longint'($signed(a[31:16]));
    aq = longint'($signed(a[15:0]));
    bi = longint'($signed(b[31:16]));
    bq = longint'($signed(b[15:0]));
    pi = (ai * bi - aq * bq) >>> 15;
    pq = (ai * bq + aq * bi) >>> 15;
    if (pi > 32767) pi = 32767;
    if (pi < -32768) pi = -32768;
    if (pq > 32767) pq = 32767;
    if (pq < -32768) pq = -32768;
    ui = pi;
    uq = pq;
    return {ui[15:0], uq[15:0]};
  endfunction

  logic [32:0] q[$];
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  logic        hold_l;

  // Single compare process: pops the model queue for every output transfer.
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("hold_pdata", {32'd0, bus.pdata}, {32'd0, hold_d});
        chk("hold_tlast", {63'd0, bus.out_tlast}, {63'd0, hold_l});
      end
      hold_v = bus.out_tvalid && !bus.out_tready;
      hold_d = bus.pdata;
      hold_l = bus.out_tlast;
      chk("in_tready", {63'd0, bus.in_tready}, {63'd0, bus.out_tready || !bus.out_tvalid});
      if (bus.out_tvalid && bus.out_tready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 64'd1, 64'd0);
        end else begin
          logic [32:0] e;
          e = q.pop_front();
          chk("pdata", {32'd0, bus.pdata}, {32'd0, e[31:0]});
          chk("out_tlast", {63'd0, bus.out_tlast}, {63'd0, e[32]});
        end
      end
      if (bus.in_tvalid && bus.in_tready)
        q.push_back({bus.in_tlast, ref_mul(bus.adata, bus.bdata)});
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic l);
    logic acc;
    int n;
    bus.adata = a;
    bus.bdata = b;
    bus.in_tlast = l;
    bus.in_tvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = bus.in_tready && reset;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 1000);
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [15:0] rnd_comp();
    logic [15:0] c[4];
    c[0] = 16'h8000; c[1] = 16'h7FFF; c[2] = 16'h0000; c[3] = 16'h0001;
    if ($urandom_range(0, 15) == 0) return c[$urandom_range(0, 3)];
    return 16'($urandom);
  endfunction

  function automatic logic [31:0] rnd_word();
    return {rnd_comp(), rnd_comp()};
  endfunction

  task automatic single(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int edges;
    @(posedge clk);
    #1;
    bus.adata = a;
    bus.bdata = b;
    bus.in_tlast = 1'b0;
    bus.in_tvalid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_tvalid = 1'b0;
    edges = 1;
    while (!bus.out_tvalid && edges < 10) begin
      @(posedge clk);
      #1;
      edges++;
    end
    chk({name, "_latency"}, 64'(edges), 64'd3);
    chk(name, {32'd0, bus.pdata}, {32'd0, exp});
  endtask

  logic done;

  initial begin
    bus.in_tvalid = 1'b0;
    bus.in_tlast = 1'b0;
    bus.adata = '0;
    bus.bdata = '0;
    bus.out_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_tvalid", {63'd0, bus.out_tvalid}, 64'd0);
    chk("rst_out_tlast", {63'd0, bus.out_tlast}, 64'd0);
    chk("rst_pdata", {32'd0, bus.pdata}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Pin the model with hand-computed values.
    chk("model_half", {32'd0, ref_mul(32'h4000_0000, 32'h4000_0000)}, 64'h2000_0000);
    chk("model_jj", {32'd0, ref_mul(32'h0000_4000, 32'h0000_4000)}, 64'hE000_0000);
    chk("model_sat_i", {32'd0, ref_mul(32'h8000_0000, 32'h8000_0000)}, 64'h7FFF_0000);
    chk("model_sat_q", {32'd0, ref_mul(32'h8000_8000, 32'h8000_8000)}, 64'h0000_7FFF);
    chk("model_floor", {32'd0, ref_mul(32'hFFFF_0000, 32'h0001_0000)}, 64'hFFFF_0000);

    single("half", 32'h4000_0000, 32'h4000_0000, 32'h2000_0000);
    single("jj", 32'h0000_4000, 32'h0000_4000, 32'hE000_0000);
    single("sat_i", 32'h8000_0000, 32'h8000_0000, 32'h7FFF_0000);
    single("sat_q", 32'h8000_8000, 32'h8000_8000, 32'h0000_7FFF);

    // Backpressure: stall 5 cycles after 4 beats; tlast on beat index 7.
    for (int i = 0; i < 4; i++) send(rnd_word(), rnd_word(), 1'b0);
    bus.in_tvalid = 1'b0;
    bus.out_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_tready", {63'd0, bus.in_tready}, 64'd0);
      chk("stall_out_tvalid", {63'd0, bus.out_tvalid}, 64'd1);
      @(posedge clk);
      #1;
    end
    bus.out_tready = 1'b1;
    for (int i = 4; i < 12; i++) send(rnd_word(), rnd_word(), i == 7);
    bus.in_tvalid = 1'b0;

    // Full-rate streaming.
    for (int i = 0; i < 16384; i++) send(rnd_word(), rnd_word(), $urandom_range(0, 7) == 0);
    bus.in_tvalid = 1'b0;

    // Random bubbles and random downstream stalls.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 2000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.in_tvalid = 1'b0;
            @(posedge clk);
            #1;
          end
          send(rnd_word(), rnd_word(), $urandom_range(0, 3) == 0);
        end
        bus.in_tvalid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_tready = ($urandom_range(0, 3) != 0);
        end
        bus.out_tready = 1'b1;
      end
    join

    // Reset mid-stream: outputs clear at once, earlier beats never appear.
    for (int i = 0; i < 10; i++) send(rnd_word(), rnd_word(), 1'b0);
    bus.in_tvalid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_out_tvalid", {63'd0, bus.out_tvalid}, 64'd0);
    chk("midrst_pdata", {32'd0, bus.pdata}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    single("post_rst", 32'h4000_0000, 32'h0000_4000, 32'h0000_2000);
    for (int i = 0; i < 20; i++) send(rnd_word(), rnd_word(), i == 19);
    bus.in_tvalid = 1'b0;

    // Drain the pipeline and confirm every accepted beat came out.
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
